symm_orth_iter: RTL

SYMM_ORTH_ITER -- requirements
Module: symm_orth_iter

---
 rtl/symm_orth_iter.sv | 255 +++++++++++++++++++++++++
 1 files changed

// File: rtl/symm_orth_iter.sv
// symm_orth_iter: iterative symmetric orthogonalisation of an N x N fixed-point
// matrix. W is normalised by a power-of-two shift from its Frobenius sum, then
// refined with W <= (3W - (W*W^T)*W) / 2 until W*W^T is within TOL of identity
// or MAX_ITER updates have been applied. All arithmetic runs through one
// shared multiplier.
// Optional build macro SYMM_ROUND_EN: round-half-up on every >>> FW and >>> 1
// (default build uses a plain arithmetic shift, i.e. floor).
module symm_orth_iter #(
    parameter int N        = 4,
    parameter int DW       = 26,
    parameter int FW       = 16,
    parameter int MAX_ITER = 8,
    parameter int TOL      = 256
) (
    input  logic                            clk_symm,
    input  logic                            rstn_symm,
    input  logic                            go_symm,
    input  logic [N*N*DW-1:0]               b_in,
    output logic                            symm_busy,
    output logic                            symm_done,
    output logic                            isOrth,
    output logic [$clog2(MAX_ITER+1)-1:0]   iter_cnt,
    output logic [N*N*DW-1:0]               w_out
);

    localparam int IW = $clog2(N);
    localparam int CW = $clog2(MAX_ITER + 1);
    localparam int PW = 2 * DW;
    localparam int AW = 2 * DW + $clog2(N);
    localparam int SW = 2 * DW + 2 * $clog2(N);
    localparam int UW = DW + 3;
    localparam int KW = 8;

    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
    localparam logic [CW-1:0] ITER_LIM = CW'(MAX_ITER);
    localparam logic [SW-1:0] S_LIM    = SW'(1) << (2 * FW);

    localparam logic signed [DW+1:0] ONE_V = {{(DW + 1 - FW){1'b0}}, 1'b1, {FW{1'b0}}};
    localparam logic signed [DW+1:0] TOL_V = (DW + 2)'(TOL);

    localparam logic signed [AW:0]   SAT_HI_A = {{(AW + 2 - DW){1'b0}}, {(DW - 1){1'b1}}};
    localparam logic signed [AW:0]   SAT_LO_A = {{(AW + 2 - DW){1'b1}}, {(DW - 1){1'b0}}};
    localparam logic signed [UW-1:0] SAT_HI_U = {{(UW + 1 - DW){1'b0}}, {(DW - 1){1'b1}}};
    localparam logic signed [UW-1:0] SAT_LO_U = {{(UW + 1 - DW){1'b1}}, {(DW - 1){1'b0}}};

`ifdef SYMM_ROUND_EN
    localparam logic signed [AW:0]   RND_FW = (AW + 1)'(1) << (FW - 1);
    localparam logic signed [UW-1:0] RND_1  = UW'(1);
`endif

    typedef enum logic [3:0] {
        IDLE, LOAD, NORM, SHIFT, GRAM, TEST, MULQ, UPD, DONE
    } state_t;

    state_t state, state_nxt;

    logic signed [DW-1:0] w_m [N][N];
    logic signed [DW-1:0] p_m [N][N];
    logic signed [DW-1:0] q_m [N][N];

    logic [IW-1:0]        ci, cj, cl;
    logic [IW-1:0]        ci2, cj2, ci3, cj3, cl3;
    logic [SW-1:0]        s_sum;
    logic signed [AW-1:0] acc, acc_nxt;
    logic [CW-1:0]        iter_int;
    logic                 iso_int, iso_nxt, elem_ok;
    logic signed [DW-1:0] op_a, op_b;
    logic signed [PW-1:0] prod;
    logic signed [DW+1:0] diff_v, abs_v;
    logic                 last2, last3;
    logic [KW-1:0]        k_sel;

    // Matrix-product result: scale by 2^-FW, then clamp to the element range.
    function automatic logic signed [DW-1:0] mat_scale(input logic signed [AW-1:0] v);
        logic signed [AW:0] t;
        t = (AW + 1)'(v);
`ifdef SYMM_ROUND_EN
        t = t + RND_FW;
`endif
        t = t >>> FW;
        if (t > SAT_HI_A)      t = SAT_HI_A;
        else if (t < SAT_LO_A) t = SAT_LO_A;
        return t[DW-1:0];
    endfunction

    // Update result: halve, then clamp to the element range.
    function automatic logic signed [DW-1:0] upd_scale(input logic signed [UW-1:0] v);
        logic signed [UW-1:0] t;
        t = v;
`ifdef SYMM_ROUND_EN
        t = t + RND_1;
`endif
        t = t >>> 1;
        if (t > SAT_HI_U)      t = SAT_HI_U;
        else if (t < SAT_LO_U) t = SAT_LO_U;
        return t[DW-1:0];
    endfunction

    assign symm_busy = (state != IDLE);
    assign last2     = (ci == LAST_IDX) && (cj == LAST_IDX);
    assign last3     = last2 && (cl == LAST_IDX);
    assign prod      = PW'(op_a) * PW'(op_b);
    assign acc_nxt   = ((cl == '0) ? {AW{1'b0}} : acc) + AW'(prod);

    // Route the operands of the single shared multiplier by phase.
    always_comb begin
        op_a = '0;
        op_b = '0;
        case (state)
            NORM: begin op_a = w_m[ci][cj]; op_b = w_m[ci][cj]; end
            GRAM: begin op_a = w_m[ci][cl]; op_b = w_m[cj][cl]; end
            MULQ: begin op_a = p_m[ci][cl]; op_b = w_m[cl][cj]; end
            default: ;
        endcase
    end

    // Index sequencing: (i,j) raster for N*N phases, (i,j,l) with l innermost for N^3 phases.
    always_comb begin
        cj2 = (cj == LAST_IDX) ? '0 : cj + 1'b1;
        ci2 = (cj == LAST_IDX) ? ((ci == LAST_IDX) ? '0 : ci + 1'b1) : ci;
        cl3 = (cl == LAST_IDX) ? '0 : cl + 1'b1;
        cj3 = (cl == LAST_IDX) ? cj2 : cj;
        ci3 = (cl == LAST_IDX) ? ci2 : ci;
    end

    // Distance of the current P element from identity and running convergence flag.
    always_comb begin
        diff_v  = (DW + 2)'(p_m[ci][cj]) - ((ci == cj) ? ONE_V : {(DW + 2){1'b0}});
        abs_v   = diff_v[DW+1] ? -diff_v : diff_v;
        elem_ok = (abs_v <= TOL_V);
        iso_nxt = (((ci == '0) && (cj == '0)) ? 1'b1 : iso_int) & elem_ok;
    end

    // Smallest k with (S >> 2k) <= 2^(2FW); S == 0 naturally yields k = 0.
    always_comb begin
        k_sel = '0;
        for (int kk = SW / 2; kk >= 0; kk--) begin
            if ((s_sum >> (2 * kk)) <= S_LIM) k_sel = KW'(kk);
        end
    end

    // State register.
    always_ff @(posedge clk_symm) begin
        if (!rstn_symm) state <= IDLE;
        else            state <= state_nxt;
    end

    // Next-state sequencing through the normalise / test / update loop.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (go_symm) state_nxt = LOAD;
            LOAD:  state_nxt = NORM;
            NORM:  if (last2) state_nxt = SHIFT;
            SHIFT: state_nxt = GRAM;
            GRAM:  if (last3) state_nxt = TEST;
            TEST:  if (last2) state_nxt = (iso_nxt || (iter_int == ITER_LIM)) ? DONE : MULQ;
            MULQ:  if (last3) state_nxt = UPD;
            UPD:   if (last2) state_nxt = GRAM;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: matrix storage, accumulators, counters and the registered results.
    // iter_int counts the current run; iter_cnt only changes when a run completes.
    always_ff @(posedge clk_symm) begin
        if (!rstn_symm) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    w_m[i][j] <= '0;
                    p_m[i][j] <= '0;
                    q_m[i][j] <= '0;
                end
            end
            w_out     <= '0;
            iter_cnt  <= '0;
            isOrth    <= 1'b0;
            symm_done <= 1'b0;
            iter_int  <= '0;
            iso_int   <= 1'b0;
            s_sum     <= '0;
            acc       <= '0;
            ci        <= '0;
            cj        <= '0;
            cl        <= '0;
        end else begin
            symm_done <= 1'b0;
            case (state)
                LOAD: begin
                    for (int i = 0; i < N; i++) begin
                        for (int j = 0; j < N; j++) begin
                            w_m[i][j] <= b_in[(i*N+j)*DW +: DW];
                        end
                    end
                    iter_int <= '0;
                    s_sum    <= '0;
                    ci       <= '0;
                    cj       <= '0;
                    cl       <= '0;
                end
                NORM: begin
                    s_sum <= s_sum + SW'($unsigned(prod));
                    ci    <= ci2;
                    cj    <= cj2;
                end
                SHIFT: begin
                    for (int i = 0; i < N; i++) begin
                        for (int j = 0; j < N; j++) begin
                            w_m[i][j] <= w_m[i][j] >>> k_sel;
                        end
                    end
                end
                GRAM: begin
                    acc <= acc_nxt;
                    if (cl == LAST_IDX) p_m[ci][cj] <= mat_scale(acc_nxt);
                    ci <= ci3;
                    cj <= cj3;
                    cl <= cl3;
                end
                TEST: begin
                    iso_int <= iso_nxt;
                    ci      <= ci2;
                    cj      <= cj2;
                end
                MULQ: begin
                    acc <= acc_nxt;
                    if (cl == LAST_IDX) q_m[ci][cj] <= mat_scale(acc_nxt);
                    ci <= ci3;
                    cj <= cj3;
                    cl <= cl3;
                end
                UPD: begin
                    w_m[ci][cj] <= upd_scale((UW'(w_m[ci][cj]) <<< 1) + UW'(w_m[ci][cj])
                                             - UW'(q_m[ci][cj]));
                    if (last2) iter_int <= iter_int + 1'b1;
                    ci <= ci2;
                    cj <= cj2;
                end
                DONE: begin
                    for (int i = 0; i < N; i++) begin
                        for (int j = 0; j < N; j++) begin
                            w_out[(i*N+j)*DW +: DW] <= w_m[i][j];
                        end
                    end
                    isOrth    <= iso_int;
                    iter_cnt  <= iter_int;
                    symm_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
